// File: rtl/mem_addr_seq.sv
// mem_addr_seq: registered memory-address source selector for the multicycle
// datapath, with a multi-cycle exception-vector fetch.
//
// Normal access: in IDLE, addr_req_i loads source sel_i from src_bus_i into
// mem_addr_o and holds it with mem_req_o high until mem_ready_i.
// Exception: exc_req_i latches a pending code in any state. From IDLE, a
// pending exception issues VEC_BYTES consecutive byte addresses starting at
// VEC_BASE + code*VEC_BYTES. It assembles the returned bytes little-endian
// into vec_data_o and pulses vec_valid_o for one cycle.
//
// Optional build macro: MEM_ADDR_SEQ_BADSEL_TRAP_EN
//   defined   : sel_i >= N_SRC with addr_req_i pulses err_o, no access issued
//   undefined : sel_i >= N_SRC selects source 0
//
// Ports:
//   clk_i, reset_i        clock, synchronous active-high reset
//   sel_i, src_bus_i      source index and packed sources (slot i at i*WIDTH)
//   addr_req_i            normal access request (level, sampled in IDLE)
//   exc_req_i, exc_code_i exception pulse and code
//   mem_ready_i           memory accepted current address
//   mem_rdata_i           returned byte during vector fetch
//   mem_addr_o, mem_req_o registered address / address valid
//   busy_o                not IDLE or exception pending
//   vec_valid_o, vec_data_o  assembled handler address, one-cycle valid
//   err_o                 one-cycle pulse on a rejected request
module mem_addr_seq #(
  parameter int WIDTH     = 32,
  parameter int N_SRC     = 3,
  parameter int SEL_W     = 2,
  parameter int VEC_BASE  = 253,
  parameter int VEC_BYTES = 1,
  parameter int N_EXC     = 3
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic [SEL_W-1:0]       sel_i,
  input  logic [N_SRC*WIDTH-1:0] src_bus_i,
  input  logic                   addr_req_i,
  input  logic                   exc_req_i,
  input  logic [1:0]             exc_code_i,
  input  logic                   mem_ready_i,
  input  logic [7:0]             mem_rdata_i,
  output logic [WIDTH-1:0]       mem_addr_o,
  output logic                   mem_req_o,
  output logic                   busy_o,
  output logic                   vec_valid_o,
  output logic [WIDTH-1:0]       vec_data_o,
  output logic                   err_o
);

  localparam int CNT_W = $clog2(VEC_BYTES) + 1;
  localparam logic [WIDTH-1:0] VEC_BASE_W  = WIDTH'(VEC_BASE);
  localparam logic [WIDTH-1:0] VEC_BYTES_W = WIDTH'(VEC_BYTES);
  localparam logic [CNT_W-1:0] LAST_BYTE   = CNT_W'(VEC_BYTES - 1);

  typedef enum logic [1:0] {IDLE, NORM, VEC, DONE} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] addr_q, addr_d;
  logic             req_q, req_d;
  logic             vvld_q, vvld_d;
  logic [WIDTH-1:0] vdata_q, vdata_d;
  logic             err_q, err_d;
  logic             pend_q, pend_d;
  logic [1:0]       pcode_q, pcode_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] src_sel;

  // Source mux; out-of-range indices fall back to slot 0.
  always_comb begin
    src_sel = src_bus_i[0 +: WIDTH];
    for (int i = 1; i < N_SRC; i++) begin
      if (sel_i == SEL_W'(i)) src_sel = src_bus_i[i*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    req_d   = req_q;
    vvld_d  = 1'b0;
    vdata_d = vdata_q;
    err_d   = 1'b0;
    pend_d  = pend_q;
    pcode_d = pcode_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      IDLE: begin
        if (pend_q) begin
          pend_d = 1'b0;
          if (int'(pcode_q) >= N_EXC) begin
            err_d = 1'b1;
          end else begin
            addr_d  = VEC_BASE_W + WIDTH'(pcode_q) * VEC_BYTES_W;
            cnt_d   = '0;
            vdata_d = '0;
            req_d   = 1'b1;
            state_d = VEC;
          end
        end else if (addr_req_i) begin
`ifdef MEM_ADDR_SEQ_BADSEL_TRAP_EN
          if (int'(sel_i) >= N_SRC) begin
            err_d = 1'b1;
          end else begin
            addr_d  = src_sel;
            req_d   = 1'b1;
            state_d = NORM;
          end
`else
          addr_d  = src_sel;
          req_d   = 1'b1;
          state_d = NORM;
`endif
        end
      end
      NORM: begin
        if (mem_ready_i) begin
          req_d   = 1'b0;
          state_d = IDLE;
        end
      end
      VEC: begin
        if (mem_ready_i) begin
          vdata_d[8*cnt_q +: 8] = mem_rdata_i;
          cnt_d  = cnt_q + 1'b1;
          addr_d = addr_q + 1'b1;
          if (cnt_q == LAST_BYTE) begin
            req_d   = 1'b0;
            vvld_d  = 1'b1;  // high for exactly the DONE cycle
            state_d = DONE;
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // A new exception overrides any clear above, so a pulse arriving on the
    // cycle the previous one is consumed is not lost; last code wins.
    if (exc_req_i) begin
      pend_d  = 1'b1;
      pcode_d = exc_code_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      addr_q  <= '0;
      req_q   <= 1'b0;
      vvld_q  <= 1'b0;
      vdata_q <= '0;
      err_q   <= 1'b0;
      pend_q  <= 1'b0;
      pcode_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      req_q   <= req_d;
      vvld_q  <= vvld_d;
      vdata_q <= vdata_d;
      err_q   <= err_d;
      pend_q  <= pend_d;
      pcode_q <= pcode_d;
      cnt_q   <= cnt_d;
    end
  end

  assign mem_addr_o  = addr_q;
  assign mem_req_o   = req_q;
  assign busy_o      = (state_q != IDLE) | pend_q;
  assign vec_valid_o = vvld_q;
  assign vec_data_o  = vdata_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_mem_addr_seq.sv
// Bench for mem_addr_seq (VEC_BYTES=4): table-driven normal accesses plus
// hand-written exception, collision, error and reset sequences. Expected
// accepted addresses and vector words go into queues when stimulus is
// driven and are popped when the DUT presents them.
module tb_mem_addr_seq;
  localparam int W = 32;

  logic          clk_i, reset_i;
  logic [1:0]    sel_i;
  logic [3*W-1:0] src_bus_i;
  logic          addr_req_i, exc_req_i, mem_ready_i;
  logic [1:0]    exc_code_i;
  logic [7:0]    mem_rdata_i;
  logic [W-1:0]  mem_addr_o, vec_data_o;
  logic          mem_req_o, busy_o, vec_valid_o, err_o;

  mem_addr_seq #(.WIDTH(W), .N_SRC(3), .SEL_W(2), .VEC_BASE(253),
                 .VEC_BYTES(4), .N_EXC(3)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .sel_i(sel_i), .src_bus_i(src_bus_i),
    .addr_req_i(addr_req_i), .exc_req_i(exc_req_i), .exc_code_i(exc_code_i),
    .mem_ready_i(mem_ready_i), .mem_rdata_i(mem_rdata_i),
    .mem_addr_o(mem_addr_o), .mem_req_o(mem_req_o), .busy_o(busy_o),
    .vec_valid_o(vec_valid_o), .vec_data_o(vec_data_o), .err_o(err_o));

  localparam logic [W-1:0] SRC0 = 32'hA000_0000;
  localparam logic [W-1:0] SRC1 = 32'h0000_1000;
  localparam logic [W-1:0] SRC2 = 32'h0000_0044;

  typedef struct { logic [W-1:0] addr; int len; } acc_t;
  typedef struct { logic [1:0] sel; int waits; logic [W-1:0] exp_addr; } nvec_t;

  acc_t         aq[$];
  logic [W-1:0] vq[$];
  int cmp_n = 0, fail_n = 0;
  int n_acc = 0, err_seen = 0, err_exp = 0;
  int wait_cfg = 0;
  logic ready_en = 1'b1, idle_ready = 1'b0;

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    cmp_n++;
    if (act !== exp) begin
      fail_n++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] mem_byte(input logic [W-1:0] a);
    logic [W-1:0] p;
    p = (a - 32'd260) * 32'h11;
    return p[7:0];
  endfunction

  function automatic logic [W-1:0] exp_vec(input int code);
    logic [W-1:0] b;
    b = 32'd253 + 32'(code) * 32'd4;
    return {mem_byte(b + 3), mem_byte(b + 2), mem_byte(b + 1), mem_byte(b)};
  endfunction

  // Memory responder: wait_cfg low cycles before each accept.
  initial begin
    int wcnt;
    wcnt = 0;
    mem_ready_i = 1'b0;
    mem_rdata_i = 8'h00;
    forever begin
      @(posedge clk_i);
      #2;
      if (reset_i) begin
        mem_ready_i = 1'b0;
        wcnt = 0;
      end else if (mem_req_o && ready_en) begin
        if (wcnt >= wait_cfg) begin
          mem_ready_i = 1'b1;
          wcnt = 0;
        end else begin
          mem_ready_i = 1'b0;
          wcnt++;
        end
      end else begin
        mem_ready_i = idle_ready && !mem_req_o;
        wcnt = 0;
      end
      mem_rdata_i = mem_byte(mem_addr_o);
    end
  end

  // Monitor / scoreboard.
  initial begin
    int run;
    logic prev_req, prev_acc, prev_vv;
    logic [W-1:0] prev_addr, ev;
    acc_t e;
    run = 0; prev_req = 0; prev_acc = 0; prev_vv = 0; prev_addr = '0;
    forever begin
      @(negedge clk_i);
      if (reset_i) begin
        run = 0; prev_req = 0; prev_acc = 0; prev_vv = 0;
      end else begin
        if (mem_req_o) run++;
        if (mem_req_o && prev_req && !prev_acc) chk("addr_stable", mem_addr_o, prev_addr);
        if (mem_req_o && mem_ready_i) begin
          n_acc++;
          cmp_n++;
          if (aq.size() == 0) begin
            fail_n++;
            $display("FAIL unexpected_access: got addr %h expected no access", mem_addr_o);
          end else begin
            cmp_n--;
            e = aq.pop_front();
            chk("acc_addr", mem_addr_o, e.addr);
            chk("acc_req_len", run, e.len);
          end
          run = 0;
        end
        if (vec_valid_o) begin
          cmp_n++;
          if (vq.size() == 0) begin
            fail_n++;
            $display("FAIL unexpected_vec_valid: got data %h expected no pulse", vec_data_o);
          end else begin
            cmp_n--;
            ev = vq.pop_front();
            chk("vec_data", vec_data_o, ev);
            chk("vec_single_pulse", prev_vv, 1'b0);
          end
        end
        if (err_o) err_seen++;
        prev_req = mem_req_o;
        prev_acc = mem_req_o && mem_ready_i;
        prev_addr = mem_addr_o;
        prev_vv = vec_valid_o;
      end
    end
  end

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    while (busy_o && n < 300) begin
      @(posedge clk_i); #1;
      n++;
    end
    if (busy_o) begin
      cmp_n++; fail_n++;
      $display("FAIL %s_timeout: got busy after %0d cycles expected idle", nm, n);
    end
  endtask

  task automatic do_norm(input logic [1:0] s);
    sel_i = s; addr_req_i = 1'b1;
    @(posedge clk_i); #1;
    addr_req_i = 1'b0;
  endtask

  task automatic do_exc(input logic [1:0] c);
    exc_code_i = c; exc_req_i = 1'b1;
    @(posedge clk_i); #1;
    exc_req_i = 1'b0;
  endtask

  task automatic push_vec(input int code, input int waits);
    for (int j = 0; j < 4; j++) aq.push_back('{32'd253 + 32'(code) * 32'd4 + 32'(j), waits + 1});
    vq.push_back(exp_vec(code));
  endtask

  nvec_t tbl[6];

  initial begin
    int n, base;
    tbl[0] = '{2'd1, 0, SRC1};
    tbl[1] = '{2'd2, 3, SRC2};
    tbl[2] = '{2'd0, 1, SRC0};
    tbl[3] = '{2'd2, 0, SRC2};
    tbl[4] = '{2'd1, 2, SRC1};
    tbl[5] = '{2'd0, 0, SRC0};

    reset_i = 1'b1; sel_i = '0; addr_req_i = 0; exc_req_i = 0; exc_code_i = '0;
    src_bus_i = {SRC2, SRC1, SRC0};
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_mem_addr", mem_addr_o, 0);
    chk("rst_mem_req", mem_req_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_vec_valid", vec_valid_o, 0);
    chk("rst_vec_data", vec_data_o, 0);
    chk("rst_err", err_o, 0);
    reset_i = 1'b0;
    @(posedge clk_i); #1;

    // Table of normal accesses.
    for (int i = 0; i < 6; i++) begin
      wait_idle("norm");
      wait_cfg = tbl[i].waits;
      aq.push_back('{tbl[i].exp_addr, tbl[i].waits + 1});
      do_norm(tbl[i].sel);
      chk("norm_busy", busy_o, 1'b1);
    end
    wait_idle("norm_end");
    chk("norm_drain", aq.size(), 0);

    // mem_ready with no request must not start anything.
    idle_ready = 1'b1;
    repeat (4) begin
      @(posedge clk_i); #1;
      chk("idle_ready_req", mem_req_o, 1'b0);
    end
    idle_ready = 1'b0;

    // Vector fetches; code 2 matches the documented example.
    wait_cfg = 0;
    for (int j = 0; j < 4; j++) aq.push_back('{32'd261 + 32'(j), 1});
    vq.push_back(32'h4433_2211);
    do_exc(2'd2);
    wait_idle("vec2");
    wait_cfg = 1;
    push_vec(0, 1);
    do_exc(2'd0);
    wait_idle("vec0");
    @(posedge clk_i); #1;
    chk("vec_drain", vq.size(), 0);

    // Last code wins when two exceptions arrive while pending.
    wait_cfg = 0;
    aq.push_back('{SRC2, 3});
    push_vec(1, 0);
    wait_cfg = 2;
    do_norm(2'd2);
    wait_cfg = 2;
    exc_code_i = 2'd0; exc_req_i = 1'b1;
    @(posedge clk_i); #1;
    exc_code_i = 2'd1;
    @(posedge clk_i); #1;
    exc_req_i = 1'b0;
    wait_cfg = 2;
    n = 0;
    while (aq.size() > 4 && n < 50) begin @(posedge clk_i); #1; n++; end
    wait_cfg = 0;
    wait_idle("lastwins");

    // Collision: exception during a waiting NORM access.
    wait_cfg = 3;
    aq.push_back('{SRC1, 4});
    push_vec(1, 3);
    do_norm(2'd1);
    do_exc(2'd1);
    chk("coll_busy", busy_o, 1'b1);
    wait_idle("coll");
    @(posedge clk_i); #1;
    chk("coll_drain_acc", aq.size(), 0);
    chk("coll_drain_vec", vq.size(), 0);

    // Bad exception code.
    wait_cfg = 0;
    base = err_seen;
    err_exp++;
    do_exc(2'd3);
    wait_idle("badcode");
    repeat (2) @(posedge clk_i);
    #1;
    chk("badcode_err", err_seen - base, 1);
    chk("badcode_req", mem_req_o, 1'b0);

    // Out-of-range select.
    base = err_seen;
`ifdef MEM_ADDR_SEQ_BADSEL_TRAP_EN
    err_exp++;
    do_norm(2'd3);
    chk("badsel_busy", busy_o, 1'b0);
    repeat (2) @(posedge clk_i);
    #1;
    chk("badsel_err", err_seen - base, 1);
`else
    aq.push_back('{SRC0, 1});
    do_norm(2'd3);
    wait_idle("badsel");
    repeat (2) @(posedge clk_i);
    #1;
    chk("badsel_err", err_seen - base, 0);
`endif
    chk("badsel_drain", aq.size(), 0);

    // Reset mid-vector after two bytes.
    wait_cfg = 0;
    aq.push_back('{32'd261, 1});
    aq.push_back('{32'd262, 1});
    base = n_acc;
    do_exc(2'd2);
    n = 0;
    while (n_acc < base + 2 && n < 50) begin @(posedge clk_i); #1; n++; end
    chk("midrst_accepts", n_acc - base, 2);
    reset_i = 1'b1; ready_en = 1'b0;
    @(posedge clk_i); #1;
    chk("midrst_mem_addr", mem_addr_o, 0);
    chk("midrst_mem_req", mem_req_o, 0);
    chk("midrst_busy", busy_o, 0);
    chk("midrst_vec_valid", vec_valid_o, 0);
    chk("midrst_vec_data", vec_data_o, 0);
    chk("midrst_err", err_o, 0);
    reset_i = 1'b0; ready_en = 1'b1;
    repeat (8) @(posedge clk_i);
    #1;
    chk("midrst_idle", busy_o, 1'b0);
    chk("final_acc_drain", aq.size(), 0);
    chk("final_vec_drain", vq.size(), 0);
    chk("final_err_count", err_seen, err_exp);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, fail_n);
    $finish;
  end
endmodule

// File: doc/mem_addr_seq.md
# mem_addr_seq

Parametrised, registered memory-address source selector for the multicycle datapath, replacing the fixed 3-way memory-address mux with its hard-wired exception-vector constants. It selects among N_SRC runtime address sources for normal accesses. It also runs a multi-cycle exception-vector fetch: it issues VEC_BYTES consecutive byte addresses, assembles the returned bytes and presents the handler address to the control unit. It sits between the control unit / ALU result registers and the memory address port.

## Interface
- WIDTH, 32, address/data width
- N_SRC, 3, number of runtime address sources (≥2)
- SEL_W, 2, select width; must satisfy 2^SEL_W ≥ N_SRC
- VEC_BASE, 253, byte address of exception-vector table
- VEC_BYTES, 1, bytes per vector entry (1..WIDTH/8)
- N_EXC, 3, number of exception codes
- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- sel  in  SEL_W  source index for normal access
- src_bus  in  N_SRC*WIDTH  packed sources; source i at [i*WIDTH +: WIDTH]
- addr_req  in  1  request normal access (level, sampled in IDLE)
- exc_req  in  1  exception pulse; latched as pending
- exc_code  in  2  exception code, sampled with exc_req
- mem_ready  in  1  memory accepted current address
- mem_rdata  in  8  byte returned, valid with mem_ready during vector fetch
- mem_addr  out  WIDTH  registered address to memory
- mem_req  out  1  address valid
- busy  out  1  block not in IDLE or exception pending
- vec_valid  out  1  one-cycle pulse; vec_data valid
- vec_data  out  WIDTH  assembled handler address, zero-extended
- err  out  1  one-cycle pulse on rejected request

## Operation
- States: IDLE, NORM, VEC, DONE.
- IDLE:
  - Pending exception wins over addr_req.
  - If exception pending: load mem_addr = VEC_BASE + code*VEC_BYTES, clear byte counter and vec_data, go to VEC.
  - Else if addr_req: load mem_addr = src_bus slot sel, go to NORM.
- NORM: hold mem_addr and mem_req until mem_ready; then return to IDLE.
- VEC:
  - On each mem_ready: write mem_rdata into vec_data byte[count] (little-endian), increment count and mem_addr by 1.
  - After byte VEC_BYTES-1: go to DONE.
- DONE: pulse vec_valid for one cycle; return to IDLE.
- Exception latching:
  - exc_req is latched into a pending flag plus code in any state.
  - A second exc_req while pending overwrites the code (last wins).
  - Pending is cleared on entry to VEC.
- Exception arriving during NORM: the NORM access completes first, then VEC starts.
- exc_code ≥ N_EXC: pulse err, drop the exception, stay IDLE.
- Address arithmetic: modulo 2^WIDTH; wrap past all-ones is allowed.
- Reset values: mem_addr=0, mem_req=0, busy=0, vec_valid=0, vec_data=0, err=0, pending=0, state IDLE.
- Reset mid-operation: abandon the current access immediately. No vec_valid, no err.

## Timing
- Request sampled in IDLE at edge k: mem_addr and mem_req valid from edge k (registered output, 1-cycle latency).
- mem_req high in NORM/VEC only. mem_addr stable while mem_req high and mem_ready low.
- mem_ready ignored when mem_req is low.
- Normal access with zero-wait memory: IDLE→NORM→IDLE, 2 cycles; back-to-back requests every 2 cycles.
- Vector fetch with zero-wait memory: 1 + VEC_BYTES + 1 cycles from acceptance to the vec_valid pulse.
- err is asserted the cycle after the offending sample.

## Configuration
- MEM_ADDR_SEQ_BADSEL_TRAP_EN defined:
  - sel ≥ N_SRC in IDLE with addr_req: no access issued, err pulses, state stays IDLE.
- Not defined:
  - Out-of-range sel selects source 0 and the access proceeds normally.
  - No latch or undefined value is permitted in either build.
- The exc_code range check (err on exc_code ≥ N_EXC) is always present.

## Test plan
- Normal select: src1=0x0000_1000, sel=1, addr_req=1, mem_ready=1 → mem_addr=0x1000 and mem_req=1 for one cycle, back to IDLE.
- Wait states: sel=2, src2=0x44, mem_ready low for 3 cycles → mem_addr held at 0x44 and mem_req high for 4 cycles.
- Vector fetch: VEC_BYTES=4, exc_code=2 → addresses 261, 262, 263, 264 issued. Bytes 0x11, 0x22, 0x33, 0x44 returned → vec_data=0x4433_2211 with a single vec_valid pulse.
- Collision: exc_req during NORM with mem_ready low → NORM completes first, then VEC starts at VEC_BASE+code*VEC_BYTES.
- Errors:
  - exc_code=3 with N_EXC=3 → err pulse, no mem_req.
  - sel=3: with the macro, err and no access; without it, mem_addr=src0.
- Reset mid-VEC after 2 bytes → all outputs return to reset values next cycle, no vec_valid.
